// File: rtl/mg_div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package mg_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Iteration counter width; never narrower than one bit.
   function automatic int cnt_w(input int width);
      return ($clog2(width) < 1) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/mg_div_csub.sv
// Combinational W-bit trial subtractor (s - d) with a Sklansky parallel-prefix borrow network.
module mg_div_csub #(
   parameter int W = 5
) (
   input  logic [W-1:0] s,
   input  logic [W-1:0] d,
   output logic [W-1:0] diff,
   output logic         borrow
);

   localparam int LEVELS = $clog2(W);

   // Level 0 holds per-bit (generate, propagate); level k spans blocks of 2^k bits.
   logic [LEVELS:0][W-1:0] g;
   logic [LEVELS:0][W-1:0] p;
   logic                   p_unused;

   assign g[0] = ~s & d;
   assign p[0] = ~(s ^ d);

   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      for (genvar i = 0; i < W; i++) begin : g_bit
         if (((i >> l) & 1) == 1) begin : g_merge
            localparam int J = ((i >> l) << l) - 1;
            assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][J]);
            assign p[l+1][i] = p[l][i] & p[l][J];
         end else begin : g_pass
            assign g[l+1][i] = g[l][i];
            assign p[l+1][i] = p[l][i];
         end
      end
   end

   // g[LEVELS][i] is the borrow out of bits [i:0], i.e. the borrow into bit i+1.
   assign borrow   = g[LEVELS][W-1];
   assign diff     = s ^ d ^ {g[LEVELS][W-2:0], 1'b0};
   assign p_unused = ^p[LEVELS];

endmodule

// File: rtl/mg_div_restoring.sv
// Iterative unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional MG_DIV_FAST_DIV0_EN: a zero divisor bypasses the iterations and completes on acceptance.
module mg_div_restoring
   import mg_div_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div0
);

   localparam int            CW       = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] d;
   logic [WIDTH:0]   r;
   logic [CW-1:0]    cnt;
   logic             div0_q;
   logic [WIDTH:0]   s;
   logic [WIDTH:0]   t;
   logic             borrow;
   logic             last;
   logic             fast_div0;
   logic             r_msb_unused;

   assign s    = {r[WIDTH-1:0], q[WIDTH-1]};
   assign last = (cnt == LAST_CNT);

   mg_div_csub #(
      .W (WIDTH + 1)
   ) u_csub (
      .s      (s),
      .d      ({1'b0, d}),
      .diff   (t),
      .borrow (borrow)
   );

`ifdef MG_DIV_FAST_DIV0_EN
   assign fast_div0 = (divisor == '0);
`else
   assign fast_div0 = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = fast_div0 ? DONE : BUSY;
         end
         BUSY: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: these are plain registers, not a memory array, so all of them are reset.
      if (!rst_n) begin
         q      <= '0;
         r      <= '0;
         d      <= '0;
         cnt    <= '0;
         div0_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  d      <= divisor;
                  cnt    <= '0;
                  div0_q <= (divisor == '0);
                  if (fast_div0) begin
                     q <= '1;
                     r <= {1'b0, dividend};
                  end else begin
                     q <= dividend;
                     r <= '0;
                  end
               end
            end
            BUSY: begin
               // Restore on borrow: keep the shifted partial remainder instead of the difference.
               r <= borrow ? s : t;
               q <= {q[WIDTH-2:0], ~borrow};
               if (!last) cnt <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // R < D after every iteration, so the top remainder bit is always zero once DONE.
   assign r_msb_unused = r[WIDTH];

   assign quotient  = (state == DONE) ? q            : '0;
   assign remainder = (state == DONE) ? r[WIDTH-1:0] : '0;
   assign div0      = (state == DONE) ? div0_q       : 1'b0;

endmodule

// File: tb/tb_mg_div_restoring.sv
// Self-checking bench for mg_div_restoring (WIDTH=4); honours MG_DIV_FAST_DIV0_EN for div-by-zero latency.
module tb_mg_div_restoring;

   localparam int W = 4;

`ifdef MG_DIV_FAST_DIV0_EN
   localparam int DIV0_LAT = 0;  // result visible in the cycle right after the accepting edge
`else
   localparam int DIV0_LAT = W;
`endif

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         d0;
   } res_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div0;

   res_t exp_q[$];
   int   n_cmp     = 0;
   int   n_fail    = 0;
   int   n_results = 0;
   int   cyc       = 0;

   mg_div_restoring #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div0      (div0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer division, with the divide-by-zero convention.
   function automatic res_t model(input int a, input int b);
      res_t m;
      if (b == 0) begin
         m.q  = '1;
         m.r  = a[W-1:0];
         m.d0 = 1'b1;
      end else begin
         m.q  = W'(a / b);
         m.r  = W'(a % b);
         m.d0 = 1'b0;
      end
      return m;
   endfunction

   // Scoreboard: every cycle a result is presented it must equal the oldest outstanding one.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_result", out_valid, 1'b0);
         end else begin
            check("sb_quotient",  quotient,  exp_q[0].q);
            check("sb_remainder", remainder, exp_q[0].r);
            check("sb_div0",      div0,      exp_q[0].d0);
            if (out_ready) begin
               void'(exp_q.pop_front());
               n_results <= n_results + 1;
            end
         end
      end
   end

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic send(input int a, input int b, output int acc_cyc);
      int budget = 50;
      in_valid = 1'b1;
      dividend = W'(a);
      divisor  = W'(b);
      while (!in_ready && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      check("accept_wait", in_ready, 1'b1);
      @(posedge clk); #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      exp_q.push_back(model(a, b));
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         check("busy_in_ready", in_ready, 1'b0);
         @(posedge clk); #1;
         lat++;
      end
      check("result_valid", out_valid, 1'b1);
      check("done_in_ready", in_ready, 1'b0);
   endtask

   task automatic drain(input bit random_stall);
      int budget = 60;
      while (exp_q.size() != 0 && budget > 0) begin
         out_ready = random_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(posedge clk); #1;
         budget--;
      end
      check("drain_outstanding", exp_q.size(), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      res_t m;
      int   lat;
      int   c1;
      int   c2;
      int   base;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  in_ready,  1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_quotient",  quotient,  0);
      check("rst_remainder", remainder, 0);
      check("rst_div0",      div0,      1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_in_ready", in_ready, 1'b1);

      // Pin the model with hand-worked values.
      m = model(13, 3);
      check("model_13_3_q", m.q, 4);
      check("model_13_3_r", m.r, 1);
      m = model(7, 0);
      check("model_7_0_q",  m.q, 15);
      check("model_7_0_r",  m.r, 7);
      check("model_7_0_d0", m.d0, 1'b1);
      m = model(2, 9);
      check("model_2_9_q",  m.q, 0);
      check("model_2_9_r",  m.r, 2);

      // 13/3: latency and literal result.
      out_ready = 1'b1;
      send(13, 3, c1);
      wait_valid(lat);
      check("lat_13_3", lat, W);
      check("q_13_3",   quotient,  4);
      check("r_13_3",   remainder, 1);
      check("d0_13_3",  div0,      1'b0);
      drain(1'b0);

      // Back-to-back 15/1 then 2/9 with in_valid held through the first division.
      send(15, 1, c1);
      send(2, 9, c2);
      check("b2b_interval", c2 - c1, W + 2);
      drain(1'b0);

      // Divide by zero.
      send(7, 0, c1);
      wait_valid(lat);
      check("lat_div0", lat, DIV0_LAT);
      check("q_7_0",    quotient,  15);
      check("r_7_0",    remainder, 7);
      check("d0_7_0",   div0,      1'b1);
      drain(1'b0);

      // Backpressure on 9/2 with an ignored 6/3 offered meanwhile.
      out_ready = 1'b0;
      send(9, 2, c1);
      wait_valid(lat);
      check("lat_9_2", lat, W);
      base     = n_results;
      in_valid = 1'b1;
      dividend = 4'd6;
      divisor  = 4'd3;
      repeat (5) begin
         check("bp_out_valid", out_valid, 1'b1);
         check("bp_in_ready",  in_ready,  1'b0);
         check("bp_quotient",  quotient,  4);
         check("bp_remainder", remainder, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      drain(1'b0);
      repeat (12) @(posedge clk);
      #1;
      check("bp_one_result",  n_results - base, 1);
      check("bp_quiet_valid", out_valid, 1'b0);

      // Reset during the second BUSY cycle aborts the division.
      send(14, 5, c1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_in_ready",  in_ready,  1'b1);
      check("abort_quotient",  quotient,  0);
      check("abort_remainder", remainder, 0);
      check("abort_div0",      div0,      1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_abort_valid", out_valid, 1'b0);
      send(14, 5, c1);
      wait_valid(lat);
      check("q_14_5", quotient,  2);
      check("r_14_5", remainder, 4);
      drain(1'b0);

      // Exhaustive sweep with random output stalls; the scoreboard does the checking.
      for (int a = 0; a < (1 << W); a++) begin
         for (int b = 0; b < (1 << W); b++) begin
            out_ready = 1'($urandom_range(0, 1));
            send(a, b, c1);
            drain(1'b1);
         end
      end
      check("sweep_no_leftover_valid", out_valid & ~out_ready, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
